// File: rtl/switch_link_tx.sv
// switch_link_pkg: flit and metadata layout shared by the egress stage and its bench.
// Purpose: defines flit_t (metadata + payload) and meta_t (VC tag).
// Latency/backpressure: n/a (type definitions only).
package switch_link_pkg;
    localparam int VC_W = 1;

    typedef struct packed {
        logic [VC_W-1:0] vc;
        logic [6:0]      rsvd;
    } meta_t;

    typedef struct packed {
        meta_t       metadata;
        logic [31:0] payload;
    } flit_t;
endpackage

// switch_link_tx: per-outport egress stage, 2-entry flit FIFO plus per-VC credit tracking.
// Latency: a flit accepted on cycle N can appear on link_flit/link_valid from cycle N+1.
// Backpressure: packet_sent drops while the FIFO is full; link_valid needs credit for the head VC.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   flit_in, flit_valid_in           flit offered by the switch outport
//   packet_sent                      flit accepted this cycle (combinational)
//   credit_granted[NUM_VCS]          registered copy of credit_ret_in, one pulse per return
//   link_flit, link_valid, link_ready  valid/ready link toward the PHY
//   credit_ret_in[NUM_VCS]           credit returns from the neighbour
//   credit_err                       sticky: credit returned while counter already at max
module switch_link_tx
    import switch_link_pkg::*;
#(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  flit_t              flit_in,
    input  logic               flit_valid_in,
    output logic               packet_sent,
    output logic [NUM_VCS-1:0] credit_granted,
    output flit_t              link_flit,
    output logic               link_valid,
    input  logic               link_ready,
    input  logic [NUM_VCS-1:0] credit_ret_in,
    output logic               credit_err
);
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    state_t             state_q, state_d;
    flit_t              mem_q [2];
    logic               rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      credit_q [NUM_VCS];
    logic [CW-1:0]      credit_d [NUM_VCS];
    logic [NUM_VCS-1:0] credit_granted_q;
    logic               credit_err_q, credit_err_d;

    flit_t              head;
    logic [VC_W-1:0]    head_vc;
    logic               head_has_credit;
    logic               push, pop;

    assign head    = mem_q[rd_ptr_q];
    assign head_vc = head.metadata.vc;

    always_comb begin
        head_has_credit = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (head_vc == VC_W'(v) && credit_q[v] != '0) begin
                head_has_credit = 1'b1;
            end
        end
    end

    // No pass-through when full: a pop in the same cycle does not free a slot
    // for the push. The rst term keeps the ack low while reset is held.
    assign push        = flit_valid_in && (state_q != S_FULL) && !rst;
    assign link_valid  = (state_q != S_EMPTY) && head_has_credit;
    assign pop         = link_valid && link_ready;
    assign packet_sent = push;
    assign link_flit   = (state_q == S_EMPTY) ? '0 : head;

    assign credit_granted = credit_granted_q;
    assign credit_err     = credit_err_q;

    // Occupancy FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (push) state_d = S_ONE;
            S_ONE: begin
                if (push && !pop)      state_d = S_FULL;
                else if (pop && !push) state_d = S_EMPTY;
            end
            S_FULL:  if (pop) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
    end

    // Credit counters: a decrement and a return on the same VC cancel out.
    // A lone return at the maximum saturates and flags the error.
    always_comb begin
        credit_err_d = credit_err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            credit_d[v] = credit_q[v];
            if (pop && head_vc == VC_W'(v) && !credit_ret_in[v]) begin
                credit_d[v] = credit_q[v] - CW'(1);
            end else if (credit_ret_in[v] && !(pop && head_vc == VC_W'(v))) begin
                if (credit_q[v] == CW'(BUFFER_SIZE)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_EMPTY;
            rd_ptr_q         <= 1'b0;
            wr_ptr_q         <= 1'b0;
            mem_q[0]         <= '0;
            mem_q[1]         <= '0;
            credit_granted_q <= '0;
            credit_err_q     <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= CW'(BUFFER_SIZE);
            end
        end else begin
            state_q          <= state_d;
            credit_granted_q <= credit_ret_in;
            credit_err_q     <= credit_err_d;
            for (int v = 0; v < NUM_VCS; v++) begin
                credit_q[v] <= credit_d[v];
            end
            if (push) begin
                mem_q[wr_ptr_q] <= flit_in;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end
endmodule

// File: tb/tb_switch_link_tx.sv
// Directed bench for switch_link_tx: fill/credit exhaustion, credit return, HOL blocking,
// cancelling decrement/return, saturation error and mid-operation reset.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_switch_link_tx;
    import switch_link_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    flit_t      flit_in = '0;
    logic       flit_valid_in = 1'b0;
    logic       packet_sent;
    logic [1:0] credit_granted;
    flit_t      link_flit;
    logic       link_valid;
    logic       link_ready = 1'b0;
    logic [1:0] credit_ret_in = '0;
    logic       credit_err;

    int n_vec = 0;
    int n_err = 0;

    switch_link_tx #(.NUM_VCS(2), .BUFFER_SIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_in        (flit_in),
        .flit_valid_in  (flit_valid_in),
        .packet_sent    (packet_sent),
        .credit_granted (credit_granted),
        .link_flit      (link_flit),
        .link_valid     (link_valid),
        .link_ready     (link_ready),
        .credit_ret_in  (credit_ret_in),
        .credit_err     (credit_err)
    );

    always #5 clk = ~clk;

    function automatic flit_t mk(input logic vc, input logic [31:0] pl);
        flit_t f;
        f = '0;
        f.metadata.vc = vc;
        f.payload     = pl;
        return f;
    endfunction

    // Offer n flits of one VC with link_ready high for a fixed cycle budget;
    // checks order of transfers, transfer count and acceptance count.
    task automatic stream(input logic vc, input int n, input int exp_x,
                          input logic [31:0] base, input string nm);
        int acc = 0;
        int xf  = 0;
        link_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            flit_valid_in = (acc < n);
            flit_in       = mk(vc, base + acc);
            #1;
            if (link_valid && link_ready) begin
                n_vec++;
                if (link_flit !== mk(vc, base + xf)) begin
                    n_err++;
                    $display("FAIL %s_order: got %h expected %h", nm, link_flit, mk(vc, base + xf));
                end
                xf++;
            end
            if (packet_sent) acc++;
        end
        flit_valid_in = 1'b0;
        n_vec++;
        if (xf != exp_x) begin
            n_err++;
            $display("FAIL %s_xfers: got %0d expected %0d", nm, xf, exp_x);
        end
        n_vec++;
        if (acc != n) begin
            n_err++;
            $display("FAIL %s_accepted: got %0d expected %0d", nm, acc, n);
        end
        n_vec++;
        if (link_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_blocked: link_valid got %b expected 0", nm, link_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({packet_sent, link_valid, credit_granted, credit_err} !== 5'b0 || link_flit !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got ps=%b lv=%b cg=%b ce=%b lf=%h expected all 0",
                     packet_sent, link_valid, credit_granted, credit_err, link_flit);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fill();
        stream(1'b0, 10, 8, 32'hA000, "fill");
        n_vec++;
        if (link_flit !== mk(1'b0, 32'hA008)) begin
            n_err++;
            $display("FAIL fill_head: got %h expected %h", link_flit, mk(1'b0, 32'hA008));
        end
        flit_valid_in = 1'b1;
        flit_in       = mk(1'b0, 32'hA00A);
        #1;
        n_vec++;
        if (packet_sent !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full_ack: got %b expected 0", packet_sent);
        end
        flit_valid_in = 1'b0;
    endtask

    task automatic test_credit_return();
        @(negedge clk);
        credit_ret_in = 2'b01;
        @(negedge clk);
        credit_ret_in = 2'b00;
        #1;
        n_vec++;
        if (credit_granted !== 2'b01) begin
            n_err++;
            $display("FAIL ret_granted: got %b expected 01", credit_granted);
        end
        n_vec++;
        if (link_valid !== 1'b1 || link_flit !== mk(1'b0, 32'hA008)) begin
            n_err++;
            $display("FAIL ret_xfer: got lv=%b lf=%h expected lv=1 lf=%h", link_valid, link_flit, mk(1'b0, 32'hA008));
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (credit_granted !== 2'b00 || link_valid !== 1'b0 || link_flit !== mk(1'b0, 32'hA009)) begin
            n_err++;
            $display("FAIL ret_after: got cg=%b lv=%b lf=%h expected cg=00 lv=0 lf=%h",
                     credit_granted, link_valid, link_flit, mk(1'b0, 32'hA009));
        end
    endtask

    task automatic test_hol_block();
        @(negedge clk);
        flit_valid_in = 1'b1;
        flit_in       = mk(1'b1, 32'hB000);
        #1;
        n_vec++;
        if (packet_sent !== 1'b1) begin
            n_err++;
            $display("FAIL hol_push: got %b expected 1", packet_sent);
        end
        @(negedge clk);
        flit_valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (link_valid !== 1'b0 || link_flit !== mk(1'b0, 32'hA009)) begin
                n_err++;
                $display("FAIL hol_blocked: got lv=%b lf=%h expected lv=0 lf=%h", link_valid, link_flit, mk(1'b0, 32'hA009));
            end
            @(negedge clk);
        end
        credit_ret_in = 2'b01;
        @(negedge clk);
        credit_ret_in = 2'b00;
        #1;
        n_vec++;
        if (link_valid !== 1'b1 || link_flit !== mk(1'b0, 32'hA009)) begin
            n_err++;
            $display("FAIL hol_release_vc0: got lv=%b lf=%h expected lv=1 lf=%h", link_valid, link_flit, mk(1'b0, 32'hA009));
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (link_valid !== 1'b1 || link_flit !== mk(1'b1, 32'hB000)) begin
            n_err++;
            $display("FAIL hol_release_vc1: got lv=%b lf=%h expected lv=1 lf=%h", link_valid, link_flit, mk(1'b1, 32'hB000));
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (link_valid !== 1'b0 || link_flit !== '0) begin
            n_err++;
            $display("FAIL hol_empty: got lv=%b lf=%h expected lv=0 lf=0", link_valid, link_flit);
        end
        // Restore VC1 to 8 (7 -> 8 is not an overflow)
        credit_ret_in = 2'b10;
        @(negedge clk);
        credit_ret_in = 2'b00;
        #1;
        n_vec++;
        if (credit_err !== 1'b0) begin
            n_err++;
            $display("FAIL hol_vc1_restore_err: got %b expected 0", credit_err);
        end
    endtask

    task automatic test_cancel();
        @(negedge clk);
        flit_valid_in = 1'b1;
        flit_in       = mk(1'b1, 32'hC000);
        @(negedge clk);
        flit_valid_in = 1'b0;
        credit_ret_in = 2'b10;
        #1;
        n_vec++;
        if (link_valid !== 1'b1) begin
            n_err++;
            $display("FAIL cancel_valid: got %b expected 1", link_valid);
        end
        @(negedge clk);
        credit_ret_in = 2'b00;
        #1;
        n_vec++;
        if (credit_err !== 1'b0 || credit_granted !== 2'b10 || link_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cancel_state: got ce=%b cg=%b lv=%b expected ce=0 cg=10 lv=0",
                     credit_err, credit_granted, link_valid);
        end
        // VC1 must still hold exactly 8 credits
        stream(1'b1, 9, 8, 32'hD000, "cancel_vc1");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            credit_ret_in = 2'b01;
        end
        @(negedge clk);
        credit_ret_in = 2'b00;
        #1;
        n_vec++;
        if (credit_err !== 1'b0) begin
            n_err++;
            $display("FAIL sat_at_max: got %b expected 0", credit_err);
        end
        @(negedge clk);
        credit_ret_in = 2'b01;
        @(negedge clk);
        credit_ret_in = 2'b00;
        #1;
        n_vec++;
        if (credit_err !== 1'b1) begin
            n_err++;
            $display("FAIL sat_err_set: got %b expected 1", credit_err);
        end
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if (credit_err !== 1'b1) begin
            n_err++;
            $display("FAIL sat_err_sticky: got %b expected 1", credit_err);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        link_ready    = 1'b0;
        flit_valid_in = 1'b1;
        flit_in       = mk(1'b0, 32'hE000);
        #1;
        n_vec++;
        if (packet_sent !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_push: got %b expected 1", packet_sent);
        end
        @(negedge clk);
        credit_ret_in = 2'b01;
        flit_in       = mk(1'b0, 32'hE001);
        #1;
        n_vec++;
        if (packet_sent !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_full: got %b expected 0", packet_sent);
        end
        @(negedge clk);
        credit_ret_in = 2'b00;
        #1;
        n_vec++;
        if (credit_granted !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_inflight: got %b expected 01", credit_granted);
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({packet_sent, link_valid, credit_granted, credit_err} !== 5'b0 || link_flit !== '0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got ps=%b lv=%b cg=%b ce=%b lf=%h expected all 0",
                     packet_sent, link_valid, credit_granted, credit_err, link_flit);
        end
        @(negedge clk);
        rst           = 1'b0;
        flit_valid_in = 1'b0;
        #1;
        n_vec++;
        if (link_valid !== 1'b0 || link_flit !== '0) begin
            n_err++;
            $display("FAIL rstmid_empty: got lv=%b lf=%h expected lv=0 lf=0", link_valid, link_flit);
        end
        stream(1'b0, 9, 8, 32'hF000, "rstmid_vc0");
        n_vec++;
        if (credit_err !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_err: got %b expected 0", credit_err);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_credit_return();
        test_hol_block();
        test_cancel();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
